uca_seq: RTL and testbench
==========================

UCA_SEQ -- requirements
Module: uca_seq

Interface
REQ-001 SHALL have parameter OP_W, default 4, width of ALU operation code (minimum 4).
REQ-002 SHALL have parameter MUL_LAT, default 4, cycles an accepted multiply occupies the ALU (range 1..255).
REQ-003 SHALL have parameter DIV_LAT, default 8, cycles an accepted divide occupies the ALU (range 1..255).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port valid_in  input  1  request carries a valid aluc/func pair.
REQ-007 SHALL have port aluc  input  3  main-decoder ALU class.
REQ-008 SHALL have port func  input  6  R-type function field; used only when aluc=010.
REQ-009 SHALL have port ready_out  output  1  block accepts a request this cycle.
REQ-010 SHALL have port alu_op  output  OP_W  registered ALU operation code, zero-extended from 4 bits.
REQ-011 SHALL have port op_valid  output  1  one-cycle pulse: alu_op result is due this cycle.
REQ-012 SHALL have port stall  output  1  multi-cycle operation in progress; pipeline must hold.
REQ-013 SHALL have port illegal  output  1  one-cycle pulse: accepted request had an undefined encoding.

Function
REQ-014 SHALL accept a request in cycle T when valid_in=1 and ready_out=1; requests with ready_out=0 are ignored, not queued.
REQ-015 SHALL decode aluc: 000 add 0100, 001 sub 0101, 011 and 0000, 100 or 0001, 101 slt 1000, 110 neq 1001, 111 illegal.
REQ-016 SHALL decode aluc=010 by func: 100000 add 0100, 100010 sub 0101, 011000 mul 0110, 011010 div 0111, 101010 slt 1000, 100100 and 0000, 100101 or 0001; any other func illegal.
REQ-017 SHALL, for single-cycle ops, register alu_op and pulse op_valid in cycle T+1; ready_out stays 1, so back-to-back accepts give one op_valid per cycle.
REQ-018 SHALL implement FSM states IDLE and BUSY; ready_out=1 only in IDLE; stall=1 only in BUSY.
REQ-019 SHALL, on accepting mul/div with latency L>1, enter BUSY at T+1, load counter with L-1, hold alu_op constant, decrement each cycle, and pulse op_valid in cycle T+L while returning to IDLE.
REQ-020 SHALL treat L=1 exactly as a single-cycle op (no BUSY entry).
REQ-021 SHALL size the counter to clog2(max(MUL_LAT,DIV_LAT)+1) bits; no wrap-around below zero.
REQ-022 SHALL, on illegal request, pulse illegal in T+1, keep op_valid=0, hold previous alu_op, stay in IDLE.
REQ-023 SHALL ignore valid_in and all inputs while BUSY, including in the final BUSY cycle.

Reset
REQ-024 SHALL, while rst_n=0 (including mid-BUSY), force state IDLE, counter 0, alu_op 0, op_valid 0, stall 0, illegal 0; ready_out=1.
REQ-025 SHALL accept a request in the first rising edge after rst_n deasserts.

Configuration
REQ-026 SHALL compile, with macro UCA_SEQ_XOR_EN defined, func 100110 (aluc=010) as single-cycle xor, alu_op 0011.
REQ-027 SHALL, without UCA_SEQ_XOR_EN, treat func 100110 as illegal per REQ-022.

Structure
REQ-028 SHALL place in shared package uca_pkg: aluc class codes, func codes, 4-bit ALU op codes, FSM state enum.
REQ-029 SHALL implement decode as combinational sub-module uca_dec (aluc, func -> op code, is_multi, is_mul, is_illegal); uca_seq holds FSM, counter, output registers.

Verification
REQ-030 SHALL cover: aluc=010 func=100000, valid 1 cycle -> alu_op=0100, op_valid pulse at T+1, stall=0.
REQ-031 SHALL cover: mul (func=011000), MUL_LAT=4 -> stall=1 T+1..T+3, ready_out=0 T+1..T+3, op_valid only at T+4, alu_op=0110 throughout; valid_in during busy ignored.
REQ-032 SHALL cover: aluc=000,001,011 on consecutive cycles -> alu_op 0100,0101,0000 at T+1..T+3, three op_valid pulses.
REQ-033 SHALL cover: aluc=111, then aluc=010 func=111111 -> illegal pulses, op_valid=0, alu_op unchanged.
REQ-034 SHALL cover: div DIV_LAT=8, rst_n low at T+3 -> all outputs 0, ready_out=1 immediately; add accepted after release -> op_valid next cycle.
REQ-035 SHALL cover: func=100110 -> alu_op=0011 with UCA_SEQ_XOR_EN, illegal pulse without.

Source files
------------

// File: rtl/uca_pkg.sv
// Shared encodings for the ALU-control sequencer: aluc classes, R-type func codes,
// 4-bit ALU op codes and the sequencer state enum.
package uca_pkg;

  localparam logic [2:0] ALUC_ADD   = 3'b000;
  localparam logic [2:0] ALUC_SUB   = 3'b001;
  localparam logic [2:0] ALUC_RTYPE = 3'b010;
  localparam logic [2:0] ALUC_AND   = 3'b011;
  localparam logic [2:0] ALUC_OR    = 3'b100;
  localparam logic [2:0] ALUC_SLT   = 3'b101;
  localparam logic [2:0] ALUC_NEQ   = 3'b110;
  localparam logic [2:0] ALUC_ILL   = 3'b111;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_MUL = 6'b011000;
  localparam logic [5:0] FN_DIV = 6'b011010;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_SUB = 4'b0101;
  localparam logic [3:0] OP_MUL = 4'b0110;
  localparam logic [3:0] OP_DIV = 4'b0111;
  localparam logic [3:0] OP_SLT = 4'b1000;
  localparam logic [3:0] OP_NEQ = 4'b1001;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  // Counter must hold the largest latency value, so size it for max(lat)+1 codes.
  function automatic int cnt_width(input int mul_lat, input int div_lat);
    int m;
    m = (mul_lat > div_lat) ? mul_lat : div_lat;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/uca_dec.sv
// Combinational aluc/func decoder for uca_seq.
// Optional macro UCA_SEQ_XOR_EN enables R-type func 100110 as xor.
module uca_dec
  import uca_pkg::*;
(
  input  logic [2:0] aluc,
  input  logic [5:0] func,
  output logic [3:0] op,
  output logic       is_multi,
  output logic       is_mul,
  output logic       is_illegal
);

  always_comb begin
    op         = OP_AND;
    is_multi   = 1'b0;
    is_mul     = 1'b0;
    is_illegal = 1'b0;
    case (aluc)
      ALUC_ADD: op = OP_ADD;
      ALUC_SUB: op = OP_SUB;
      ALUC_AND: op = OP_AND;
      ALUC_OR:  op = OP_OR;
      ALUC_SLT: op = OP_SLT;
      ALUC_NEQ: op = OP_NEQ;
      ALUC_RTYPE: begin
        case (func)
          FN_ADD: op = OP_ADD;
          FN_SUB: op = OP_SUB;
          FN_MUL: begin
            op       = OP_MUL;
            is_multi = 1'b1;
            is_mul   = 1'b1;
          end
          FN_DIV: begin
            op       = OP_DIV;
            is_multi = 1'b1;
          end
          FN_SLT: op = OP_SLT;
          FN_AND: op = OP_AND;
          FN_OR:  op = OP_OR;
`ifdef UCA_SEQ_XOR_EN
          FN_XOR: op = OP_XOR;
`endif
          default: is_illegal = 1'b1;
        endcase
      end
      default: is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/uca_seq.sv
// ALU-control sequencer: decodes aluc/func, registers alu_op and stalls for multi-cycle mul/div.
// Optional macro UCA_SEQ_XOR_EN (handled in uca_dec) adds single-cycle xor.
//
// state   | meaning
// IDLE    | ready_out=1, accepts a request every cycle
// BUSY    | mul/div in flight, counter running down, inputs ignored, stall=1
module uca_seq
  import uca_pkg::*;
#(
  parameter int OP_W    = 4,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_in,
  input  logic [2:0]      aluc,
  input  logic [5:0]      func,
  output logic            ready_out,
  output logic [OP_W-1:0] alu_op,
  output logic            op_valid,
  output logic            stall,
  output logic            illegal
);

  localparam int CNT_W = cnt_width(MUL_LAT, DIV_LAT);
  localparam logic [CNT_W-1:0] MUL_LD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LD = CNT_W'(DIV_LAT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       op_q, op_d;
  logic             op_valid_q, op_valid_d;
  logic             illegal_q, illegal_d;

  logic [3:0]       dec_op;
  logic             dec_multi, dec_mul, dec_ill;
  logic [CNT_W-1:0] lat_ld;

  uca_dec u_dec (
    .aluc       (aluc),
    .func       (func),
    .op         (dec_op),
    .is_multi   (dec_multi),
    .is_mul     (dec_mul),
    .is_illegal (dec_ill)
  );

  assign lat_ld = dec_mul ? MUL_LD : DIV_LD;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    op_valid_d = 1'b0;
    illegal_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (valid_in) begin
          if (dec_ill) begin
            illegal_d = 1'b1;
          end else begin
            op_d = dec_op;
            // A latency of 1 loads zero and is treated as a plain single-cycle op.
            if (dec_multi && (lat_ld != '0)) begin
              state_d = ST_BUSY;
              cnt_d   = lat_ld;
            end else begin
              op_valid_d = 1'b1;
            end
          end
        end
      end
      ST_BUSY: begin
        // Leave on the last busy cycle so op_valid lands together with ready_out.
        if (cnt_q <= CNT_W'(1)) begin
          state_d    = ST_IDLE;
          cnt_d      = '0;
          op_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      op_q       <= '0;
      op_valid_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      op_valid_q <= op_valid_d;
      illegal_q  <= illegal_d;
    end
  end

  assign ready_out = (state_q == ST_IDLE);
  assign stall     = (state_q == ST_BUSY);
  assign alu_op    = OP_W'(op_q);
  assign op_valid  = op_valid_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_uca_seq.sv
// Randomized bench for uca_seq against a cycle-number reference model.
// Honours UCA_SEQ_XOR_EN when building expectations for func 100110.
module tb_uca_seq;

  localparam int OP_W    = 4;
  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 8;

  logic            clk      = 1'b0;
  logic            rst_n    = 1'b0;
  logic            valid_in = 1'b0;
  logic [2:0]      aluc     = 3'd0;
  logic [5:0]      func     = 6'd0;
  logic            ready_out;
  logic [OP_W-1:0] alu_op;
  logic            op_valid;
  logic            stall;
  logic            illegal;

  int checks = 0;
  int errors = 0;

  // Model: everything is expressed as absolute cycle numbers of future events.
  int         cyc     = 0;
  int         free_at = 0;
  int         ov_at   = -1;
  int         ill_at  = -1;
  int         pend_at = -1;
  logic [3:0] m_op    = 4'd0;
  logic [3:0] pend_op = 4'd0;
  string      phase   = "init";

  always #5 clk = ~clk;

  uca_seq #(
    .OP_W    (OP_W),
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_in  (valid_in),
    .aluc      (aluc),
    .func      (func),
    .ready_out (ready_out),
    .alu_op    (alu_op),
    .op_valid  (op_valid),
    .stall     (stall),
    .illegal   (illegal)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s/%s cycle %0d: got %0h expected %0h", phase, tag, cyc, obs, exp);
    end
  endtask

  function automatic void ref_dec(input logic [2:0] a, input logic [5:0] f,
                                  output logic ill, output logic [3:0] op, output int lat);
    ill = 1'b0;
    op  = 4'b0000;
    lat = 1;
    case (a)
      3'b000: op = 4'b0100;
      3'b001: op = 4'b0101;
      3'b011: op = 4'b0000;
      3'b100: op = 4'b0001;
      3'b101: op = 4'b1000;
      3'b110: op = 4'b1001;
      3'b010: begin
        case (f)
          6'b100000: op = 4'b0100;
          6'b100010: op = 4'b0101;
          6'b011000: begin op = 4'b0110; lat = MUL_LAT; end
          6'b011010: begin op = 4'b0111; lat = DIV_LAT; end
          6'b101010: op = 4'b1000;
          6'b100100: op = 4'b0000;
          6'b100101: op = 4'b0001;
`ifdef UCA_SEQ_XOR_EN
          6'b100110: op = 4'b0011;
`endif
          default:   ill = 1'b1;
        endcase
      end
      default: ill = 1'b1;
    endcase
  endfunction

  // Called just after a rising edge; drives one cycle, checks it, then advances.
  task automatic do_cycle(input logic v, input logic [2:0] a, input logic [5:0] f);
    logic       ill;
    logic [3:0] op;
    int         lat;
    logic       rdy;
    valid_in = v;
    aluc     = a;
    func     = f;
    if (cyc == pend_at) m_op = pend_op;
    rdy = (cyc >= free_at);
    #4;
    chk("ready_out", 32'(ready_out), 32'(rdy));
    chk("stall",     32'(stall),     32'(!rdy));
    chk("op_valid",  32'(op_valid),  32'(cyc == ov_at));
    chk("illegal",   32'(illegal),   32'(cyc == ill_at));
    chk("alu_op",    32'(alu_op),    32'(m_op));
    if (rdy && v) begin
      ref_dec(a, f, ill, op, lat);
      if (ill) begin
        ill_at = cyc + 1;
      end else begin
        pend_op = op;
        pend_at = cyc + 1;
        ov_at   = cyc + lat;
        free_at = cyc + lat;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    valid_in = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk("rst_alu_op",   32'(alu_op),    32'd0);
    chk("rst_op_valid", 32'(op_valid),  32'd0);
    chk("rst_stall",    32'(stall),     32'd0);
    chk("rst_illegal",  32'(illegal),   32'd0);
    chk("rst_ready",    32'(ready_out), 32'd1);
    m_op    = 4'd0;
    pend_at = -1;
    ov_at   = -1;
    ill_at  = -1;
    free_at = 0;
    @(posedge clk);
    #1;
    cyc++;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [5:0] fsel [10];
    fsel = '{6'b100000, 6'b100010, 6'b011000, 6'b011010, 6'b101010,
             6'b100100, 6'b100101, 6'b100110, 6'b111111, 6'b000000};

    repeat (2) @(posedge clk);
    #1;
    phase = "reset";
    do_reset();

    phase = "add_rtype";
    do_cycle(1'b1, 3'b010, 6'b100000);
    repeat (2) do_cycle(1'b0, 3'b000, 6'd0);

    phase = "mul_busy";
    do_cycle(1'b1, 3'b010, 6'b011000);
    repeat (3) do_cycle(1'b1, 3'b001, 6'd0);
    repeat (2) do_cycle(1'b0, 3'b000, 6'd0);

    phase = "back2back";
    do_cycle(1'b1, 3'b000, 6'd0);
    do_cycle(1'b1, 3'b001, 6'd0);
    do_cycle(1'b1, 3'b011, 6'd0);
    repeat (2) do_cycle(1'b0, 3'b000, 6'd0);

    phase = "illegal";
    do_cycle(1'b1, 3'b111, 6'd0);
    do_cycle(1'b1, 3'b010, 6'b111111);
    repeat (2) do_cycle(1'b0, 3'b000, 6'd0);

    phase = "div_reset";
    do_cycle(1'b1, 3'b010, 6'b011010);
    repeat (2) do_cycle(1'b1, 3'b000, 6'd0);
    do_reset();
    do_cycle(1'b1, 3'b000, 6'd0);
    repeat (2) do_cycle(1'b0, 3'b000, 6'd0);

    phase = "xor";
    do_cycle(1'b1, 3'b010, 6'b100110);
    repeat (2) do_cycle(1'b0, 3'b000, 6'd0);

    phase = "random";
    for (int i = 0; i < 3000; i++) begin
      logic       v;
      logic [2:0] a;
      logic [5:0] f;
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        v = ($urandom_range(0, 3) != 0);
        a = ($urandom_range(0, 1) == 0) ? 3'b010 : 3'($urandom_range(0, 7));
        f = ($urandom_range(0, 7) == 0) ? 6'($urandom) : fsel[$urandom_range(0, 9)];
        do_cycle(v, a, f);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
